// File: rtl/net_frame_gen_if.sv
// net_frame_gen_if: command bus and AXI-stream beat bus for net_frame_gen.
// master = frame generator side, slave = command source / stream consumer.
interface net_frame_gen_if #(
   parameter int ROWS            = 32,
   parameter int INPUT_LENGTH    = 16,
   parameter int AXIS_KEEP_WIDTH = (ROWS * INPUT_LENGTH) / 8,
   parameter int AXIS_USER_WIDTH = 8,
   parameter int LEN_WIDTH       = 20
);
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [LEN_WIDTH-1:0]         cmd_len;
   logic [AXIS_USER_WIDTH-1:0]   cmd_tag;
   logic [INPUT_LENGTH-1:0]      cmd_seed;

   logic [ROWS*INPUT_LENGTH-1:0] net_data_in;
   logic                         net_valid_in;
   logic [AXIS_KEEP_WIDTH-1:0]   net_data_tkeep;
   logic                         net_data_tlast;
   logic [AXIS_USER_WIDTH-1:0]   net_data_tuser;
   logic                         net_tx_rdy;

   modport master (
      input  cmd_valid, cmd_len, cmd_tag, cmd_seed, net_tx_rdy,
      output cmd_ready, net_data_in, net_valid_in, net_data_tkeep,
             net_data_tlast, net_data_tuser
   );

   modport slave (
      output cmd_valid, cmd_len, cmd_tag, cmd_seed, net_tx_rdy,
      input  cmd_ready, net_data_in, net_valid_in, net_data_tkeep,
             net_data_tlast, net_data_tuser
   );
endinterface

// File: rtl/net_frame_gen.sv
// net_frame_gen: AXI-stream frame source emitting counting-pattern lanes.
// Each accepted command (len, tag, seed) becomes ceil(len/64) beats; lane i of
// beat b carries seed + b*ROWS + i. Optional statistics counters are built when
// NET_FRAME_GEN_STATS_EN is defined; otherwise the counter ports read zero.
module net_frame_gen #(
   parameter int ROWS            = 32,
   parameter int INPUT_LENGTH    = 16,
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_USER_WIDTH = 8,
   parameter int LEN_WIDTH       = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   net_frame_gen_if.master      bus,
   output logic                 busy,
   output logic                 len_err,
   output logic [31:0]          frame_cnt,
   output logic [31:0]          beat_cnt,
   output logic [31:0]          stall_cnt
);

   localparam int OFF_W = $clog2(AXIS_KEEP_WIDTH);

   if (ROWS * INPUT_LENGTH != AXIS_DATA_WIDTH) begin : g_width_check
      $error("ROWS*INPUT_LENGTH must equal AXIS_DATA_WIDTH");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t                       state_q, state_d;
   logic [LEN_WIDTH-1:0]         len_q, len_d;
   logic [LEN_WIDTH-1:0]         total_q, total_d;
   logic [LEN_WIDTH-1:0]         beat_q, beat_d;
   logic [AXIS_DATA_WIDTH-1:0]   data_q, data_d;
   logic [AXIS_KEEP_WIDTH-1:0]   keep_q, keep_d;
   logic                         last_q, last_d;
   logic [AXIS_USER_WIDTH-1:0]   user_q, user_d;
   logic                         len_err_q;

   logic                         accept;
   logic                         zero_cmd;
   logic                         hs;
   logic [LEN_WIDTH-1:0]         cmd_total;
   logic                         next_is_last;

   function automatic logic [AXIS_KEEP_WIDTH-1:0] last_keep(input logic [LEN_WIDTH-1:0] len);
      logic [OFF_W-1:0] rem;
      rem = len[OFF_W-1:0];
      if (rem == '0) return '1;
      return (AXIS_KEEP_WIDTH'(1) << rem) - AXIS_KEEP_WIDTH'(1);
   endfunction

   assign accept       = (state_q == IDLE) && bus.cmd_valid && (bus.cmd_len != '0);
   assign zero_cmd     = (state_q == IDLE) && bus.cmd_valid && (bus.cmd_len == '0);
   assign hs           = (state_q == SEND) && bus.net_tx_rdy;
   assign cmd_total    = (bus.cmd_len >> OFF_W) + LEN_WIDTH'(|bus.cmd_len[OFF_W-1:0]);
   assign next_is_last = (beat_q + LEN_WIDTH'(2)) == total_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: start on a non-empty command, finish on the last-beat handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)      state_d = SEND;
         SEND:    if (hs && last_q) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // FSM outputs; cmd_ready is gated by rst so it reads low throughout reset
   always_comb begin
      bus.cmd_ready    = (state_q == IDLE) && !rst;
      bus.net_valid_in = (state_q == SEND);
      busy             = (state_q == SEND);
   end

   // Beat datapath: load beat 0 on accept, step every lane by ROWS per handshake
   always_comb begin
      len_d   = len_q;
      total_d = total_q;
      beat_d  = beat_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      user_d  = user_q;
      if (accept) begin
         len_d   = bus.cmd_len;
         total_d = cmd_total;
         beat_d  = '0;
         user_d  = bus.cmd_tag;
         last_d  = (cmd_total == LEN_WIDTH'(1));
         keep_d  = (cmd_total == LEN_WIDTH'(1)) ? last_keep(bus.cmd_len) : '1;
         for (int unsigned i = 0; i < ROWS; i++)
            data_d[i*INPUT_LENGTH +: INPUT_LENGTH] = bus.cmd_seed + INPUT_LENGTH'(i);
      end else if (hs) begin
         if (last_q) begin
            last_d = 1'b0;
         end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
            last_d = next_is_last;
            keep_d = next_is_last ? last_keep(len_q) : '1;
            for (int unsigned i = 0; i < ROWS; i++)
               data_d[i*INPUT_LENGTH +: INPUT_LENGTH] =
                  data_q[i*INPUT_LENGTH +: INPUT_LENGTH] + INPUT_LENGTH'(ROWS);
         end
      end
   end

   // Datapath registers and the zero-length error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         total_q   <= '0;
         beat_q    <= '0;
         data_q    <= '0;
         keep_q    <= '0;
         last_q    <= 1'b0;
         user_q    <= '0;
         len_err_q <= 1'b0;
      end else begin
         len_q     <= len_d;
         total_q   <= total_d;
         beat_q    <= beat_d;
         data_q    <= data_d;
         keep_q    <= keep_d;
         last_q    <= last_d;
         user_q    <= user_d;
         len_err_q <= zero_cmd;
      end
   end

   assign bus.net_data_in    = data_q;
   assign bus.net_data_tkeep = keep_q;
   assign bus.net_data_tlast = last_q;
   assign bus.net_data_tuser = user_q;
   assign len_err            = len_err_q;

`ifdef NET_FRAME_GEN_STATS_EN
   logic [31:0] frame_cnt_q, beat_cnt_q, stall_cnt_q;

   // Free-running statistics, wrapping at 2^32, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (hs && last_q)                        frame_cnt_q <= frame_cnt_q + 32'd1;
         if (hs)                                  beat_cnt_q  <= beat_cnt_q + 32'd1;
         if ((state_q == SEND) && !bus.net_tx_rdy) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign beat_cnt  = beat_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign frame_cnt = '0;
   assign beat_cnt  = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_net_frame_gen.sv
// tb_net_frame_gen: directed, table-driven check of net_frame_gen.
module tb_net_frame_gen;

`ifdef NET_FRAME_GEN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        busy, len_err;
   logic [31:0] frame_cnt, beat_cnt, stall_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   net_frame_gen_if bus ();

   net_frame_gen dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
      .busy      (busy),
      .len_err   (len_err),
      .frame_cnt (frame_cnt),
      .beat_cnt  (beat_cnt),
      .stall_cnt (stall_cnt)
   );

   typedef struct {
      logic [19:0] len;
      logic [15:0] seed;
      logic [7:0]  tag;
      int          beats;
      logic [63:0] lkeep;
      logic [15:0] lane0;
      logic [15:0] lane16;
   } vec_t;

   vec_t vecs[6];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lane(input int i);
      logic [511:0] d;
      d = bus.net_data_in;
      return d[i*16 +: 16];
   endfunction

   task automatic check_beat(input logic [15:0] seed, input int b, input logic [7:0] tag,
                             input logic [63:0] keep, input logic last);
      logic [15:0] e;
      chk($sformatf("valid b%0d", b), 64'(bus.net_valid_in), 64'(1));
      chk($sformatf("tuser b%0d", b), 64'(bus.net_data_tuser), 64'(tag));
      chk($sformatf("tkeep b%0d", b), bus.net_data_tkeep, keep);
      chk($sformatf("tlast b%0d", b), 64'(bus.net_data_tlast), 64'(last));
      for (int i = 0; i < 32; i++) begin
         e = seed + 16'(b * 32 + i);
         chk($sformatf("lane b%0d i%0d", b, i), 64'(lane(i)), 64'(e));
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic set_cmd(input logic [19:0] len, input logic [15:0] seed, input logic [7:0] tag);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = len;
      bus.cmd_seed  = seed;
      bus.cmd_tag   = tag;
   endtask

   initial begin
      vecs[0] = '{len: 20'd64,  seed: 16'h0000, tag: 8'h5A, beats: 1,
                  lkeep: 64'hFFFF_FFFF_FFFF_FFFF, lane0: 16'h0000, lane16: 16'h0010};
      vecs[1] = '{len: 20'd130, seed: 16'hFFF0, tag: 8'h3C, beats: 3,
                  lkeep: 64'h3, lane0: 16'hFFF0, lane16: 16'h0000};
      vecs[2] = '{len: 20'd1,   seed: 16'h1234, tag: 8'h01, beats: 1,
                  lkeep: 64'h1, lane0: 16'h1234, lane16: 16'h1244};
      vecs[3] = '{len: 20'd65,  seed: 16'h0007, tag: 8'hFF, beats: 2,
                  lkeep: 64'h1, lane0: 16'h0007, lane16: 16'h0017};
      vecs[4] = '{len: 20'd200, seed: 16'h8000, tag: 8'h11, beats: 4,
                  lkeep: 64'hFF, lane0: 16'h8000, lane16: 16'h8010};
      vecs[5] = '{len: 20'd63,  seed: 16'hABCD, tag: 8'h80, beats: 1,
                  lkeep: 64'h7FFF_FFFF_FFFF_FFFF, lane0: 16'hABCD, lane16: 16'hABDD};

      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_len    = '0;
      bus.cmd_seed   = '0;
      bus.cmd_tag    = '0;
      bus.net_tx_rdy = 1'b1;

      // reset values
      tick();
      tick();
      chk("rst cmd_ready", 64'(bus.cmd_ready), 64'(0));
      chk("rst valid", 64'(bus.net_valid_in), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst tlast", 64'(bus.net_data_tlast), 64'(0));
      chk("rst len_err", 64'(len_err), 64'(0));
      chk("rst tkeep", bus.net_data_tkeep, 64'(0));
      chk("rst tuser", 64'(bus.net_data_tuser), 64'(0));
      chk("rst data", 64'(bus.net_data_in[63:0]), 64'(0));
      chk("rst frame_cnt", 64'(frame_cnt), 64'(0));
      chk("rst beat_cnt", 64'(beat_cnt), 64'(0));
      chk("rst stall_cnt", 64'(stall_cnt), 64'(0));
      rst = 1'b0;
      tick();
      chk("post-rst cmd_ready", 64'(bus.cmd_ready), 64'(1));

      // table-driven frames, downstream always ready
      for (int k = 0; k < 6; k++) begin
         set_cmd(vecs[k].len, vecs[k].seed, vecs[k].tag);
         chk($sformatf("v%0d cmd_ready", k), 64'(bus.cmd_ready), 64'(1));
         tick();
         bus.cmd_valid = 1'b0;
         for (int b = 0; b < vecs[k].beats; b++) begin
            if (b == 0) begin
               chk($sformatf("v%0d lane0", k), 64'(lane(0)), 64'(vecs[k].lane0));
               chk($sformatf("v%0d lane16", k), 64'(lane(16)), 64'(vecs[k].lane16));
            end
            check_beat(vecs[k].seed, b, vecs[k].tag,
                       (b == vecs[k].beats - 1) ? vecs[k].lkeep : 64'hFFFF_FFFF_FFFF_FFFF,
                       b == vecs[k].beats - 1);
            chk($sformatf("v%0d busy", k), 64'(busy), 64'(1));
            chk($sformatf("v%0d cmd_ready in SEND", k), 64'(bus.cmd_ready), 64'(0));
            tick();
         end
         chk($sformatf("v%0d idle valid", k), 64'(bus.net_valid_in), 64'(0));
         chk($sformatf("v%0d idle busy", k), 64'(busy), 64'(0));
         chk($sformatf("v%0d idle cmd_ready", k), 64'(bus.cmd_ready), 64'(1));
      end

      // backpressure: beat1 of a 128-byte frame stalled for 5 cycles
      do_reset();
      set_cmd(20'd128, 16'h0100, 8'h22);
      tick();
      bus.cmd_valid = 1'b0;
      check_beat(16'h0100, 0, 8'h22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      tick();
      bus.net_tx_rdy = 1'b0;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk($sformatf("stall%0d lane0", s), 64'(lane(0)), 64'(16'h0120));
         chk($sformatf("stall%0d lane31", s), 64'(lane(31)), 64'(16'h013F));
         chk($sformatf("stall%0d valid", s), 64'(bus.net_valid_in), 64'(1));
         chk($sformatf("stall%0d tlast", s), 64'(bus.net_data_tlast), 64'(1));
         chk($sformatf("stall%0d tkeep", s), bus.net_data_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
         chk($sformatf("stall%0d tuser", s), 64'(bus.net_data_tuser), 64'(8'h22));
      end
      bus.net_tx_rdy = 1'b1;
      tick();
      chk("stall done valid", 64'(bus.net_valid_in), 64'(0));
      chk("stall_cnt", 64'(stall_cnt), STATS ? 64'(5) : 64'(0));
      chk("beat_cnt", 64'(beat_cnt), STATS ? 64'(2) : 64'(0));
      chk("frame_cnt", 64'(frame_cnt), STATS ? 64'(1) : 64'(0));

      // back-to-back commands with cmd_valid held: exactly one bubble
      set_cmd(20'd64, 16'h0010, 8'h01);
      tick();
      set_cmd(20'd64, 16'h0020, 8'h02);
      chk("b2b A valid", 64'(bus.net_valid_in), 64'(1));
      chk("b2b A lane0", 64'(lane(0)), 64'(16'h0010));
      chk("b2b A cmd_ready", 64'(bus.cmd_ready), 64'(0));
      tick();
      chk("b2b bubble valid", 64'(bus.net_valid_in), 64'(0));
      chk("b2b bubble cmd_ready", 64'(bus.cmd_ready), 64'(1));
      tick();
      bus.cmd_valid = 1'b0;
      check_beat(16'h0020, 0, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      tick();
      chk("b2b B done valid", 64'(bus.net_valid_in), 64'(0));

      // zero-length command
      set_cmd(20'd0, 16'h5555, 8'h77);
      chk("len0 pre len_err", 64'(len_err), 64'(0));
      tick();
      bus.cmd_valid = 1'b0;
      chk("len0 len_err", 64'(len_err), 64'(1));
      chk("len0 valid", 64'(bus.net_valid_in), 64'(0));
      chk("len0 cmd_ready", 64'(bus.cmd_ready), 64'(1));
      chk("len0 busy", 64'(busy), 64'(0));
      tick();
      chk("len0 len_err drop", 64'(len_err), 64'(0));
      chk("len0 valid later", 64'(bus.net_valid_in), 64'(0));

      // reset during beat 3 of a 10-beat frame
      do_reset();
      set_cmd(20'd640, 16'h0040, 8'h09);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid b3 lane0", 64'(lane(0)), 64'(16'h00A0));
      chk("mid b3 tlast", 64'(bus.net_data_tlast), 64'(0));
      rst = 1'b1;
      #1;
      chk("mid rst valid", 64'(bus.net_valid_in), 64'(0));
      chk("mid rst cmd_ready", 64'(bus.cmd_ready), 64'(0));
      chk("mid rst busy", 64'(busy), 64'(0));
      chk("mid rst data", 64'(bus.net_data_in[63:0]), 64'(0));
      chk("mid rst tkeep", bus.net_data_tkeep, 64'(0));
      tick();
      rst = 1'b0;
      tick();
      set_cmd(20'd64, 16'h0099, 8'h33);
      tick();
      bus.cmd_valid = 1'b0;
      check_beat(16'h0099, 0, 8'h33, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      tick();
      chk("fresh done valid", 64'(bus.net_valid_in), 64'(0));
      chk("fresh beat_cnt", 64'(beat_cnt), STATS ? 64'(1) : 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
